// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_R = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Pull the addressed byte/half lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input size_e       size,
                                               input logic        uns);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {off, 3'b000};
    sh_h = word >> {off[1], 4'b0000};
    case (size)
      SZ_B:    lane_extract = {{24{~uns & sh_b[7]}}, sh_b[7:0]};
      SZ_H:    lane_extract = {{16{~uns & sh_h[15]}}, sh_h[15:0]};
      default: lane_extract = word;
    endcase
  endfunction

  // Replace the addressed byte/half lane of a word with the low bits of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input size_e       size);
    logic [4:0]  amt;
    logic [31:0] mask;
    amt  = (size == SZ_H) ? {off[1], 4'b0000} : {off, 3'b000};
    mask = ((size == SZ_H) ? 32'h0000_FFFF : 32'h0000_00FF) << amt;
    if (size == SZ_W) lane_merge = wdata;
    else              lane_merge = (word & ~mask) | ((wdata << amt) & mask);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane extract/extend (load path) and lane merge (store path).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  // Both lane functions evaluated on the same memory word.
  always_comb begin
    load_data = lane_extract(rdata, off, size_e'(size), uns);
    merged    = lane_merge(rdata, wdata, off, size_e'(size));
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte/half/word loads, word stores, sub-word stores as RMW.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [31:0]     req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic [4:0]      resp_rd_o,
  output logic            misalign_o,
  output logic [31:0]     exc_addr_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [31:0]     mem_waddr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [31:0]     mem_raddr_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  state_e      state;
  logic [29:0] lat_word;
  logic [1:0]  lat_off;
  size_e       lat_size;
  logic [15:0] lat_wdata;

  size_e       size_in;
  logic        misaligned;
  logic        accept;
  logic [31:0] req_word_addr;
  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Word address of the request; bits above ADDR_W pass through for the memory to ignore.
  assign req_word_addr = {req_addr_i[31:ADDR_W], req_addr_i[ADDR_W-1:2], 2'b00};
  assign req_ready_o   = (state == IDLE);
  assign accept        = req_valid_i & req_ready_o;
  assign size_in       = size_e'(req_size_i);

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    case (size_in)
      SZ_H:    misaligned = req_addr_i[0];
      SZ_W:    misaligned = (req_addr_i[1:0] != 2'b00);
      SZ_R:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // One shared aligner: request lane in IDLE (loads), latched lane in MERGE (stores).
  assign al_off  = (state == MERGE) ? lat_off  : req_addr_i[1:0];
  assign al_size = (state == MERGE) ? lat_size : req_size_i;

  lsu_align u_align (
    .rdata     (mem_rdata_i),
    .wdata     ({16'h0000, lat_wdata}),
    .off       (al_off),
    .size      (al_size),
    .uns       (req_unsigned_i),
    .load_data (load_data),
    .merged    (merged)
  );

  // Memory port drive: word store in accept cycle, merged write in MERGE, forced low in reset.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_waddr_o = req_word_addr;
    mem_raddr_o = req_word_addr;
    mem_wdata_o = '0;
    if (state == MERGE) begin
      mem_raddr_o = {lat_word, 2'b00};
      mem_waddr_o = {lat_word, 2'b00};
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_wdata_o = merged;
    end else if (accept && req_we_i && !misaligned && size_in == SZ_W) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_wdata_o = req_wdata_i;
    end
    if (!rst) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_waddr_o = '0;
      mem_raddr_o = '0;
      mem_wdata_o = '0;
    end
  end

  // Control FSM with registered response and exception outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_rd_o    <= '0;
      misalign_o   <= 1'b0;
      exc_addr_o   <= '0;
      lat_word     <= '0;
      lat_off      <= '0;
      lat_size     <= SZ_B;
      lat_wdata    <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
              exc_addr_o <= req_addr_i;
            end else if (!req_we_i) begin
              resp_valid_o <= 1'b1;
              resp_rdata_o <= load_data;
              resp_rd_o    <= req_rd_i;
            end else if (size_in != SZ_W) begin
              lat_word  <= req_word_addr[31:2];
              lat_off   <= req_addr_i[1:0];
              lat_size  <= size_in;
              lat_wdata <= req_wdata_i[15:0];
              state     <= MERGE;
            end
          end
        end
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word-addressed memory behind it.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;
  logic        misalign_o;
  logic [31:0] exc_addr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int unsigned wr_cnt = 0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(10), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o),
    .misalign_o(misalign_o), .exc_addr_o(exc_addr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i)
  );

  // Data memory: combinational read, write on posedge, plus a bench preload port.
  assign mem_rdata_i = mem[mem_raddr_o[9:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_req_o && mem_we_o) begin
      mem[mem_waddr_o[9:2]] <= mem_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = byte_addr[9:2]; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        exp_resp;
    logic [31:0] exp_data;
    logic        exp_mis;
    int unsigned exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                              input logic exp_resp, input logic [31:0] exp_data,
                              input logic exp_mis, input int unsigned exp_wr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.exp_resp = exp_resp; v.exp_data = exp_data; v.exp_mis = exp_mis; v.exp_wr = exp_wr;
    return v;
  endfunction

  vec_t        vecs[18];
  int unsigned w0;

  initial begin
    vecs[0]  = mk(0, 2'b00, 0, 32'h41,  0,            1,  1, 32'hFFFF_FFAA, 0, 0);
    vecs[1]  = mk(0, 2'b00, 1, 32'h41,  0,            2,  1, 32'h0000_00AA, 0, 0);
    vecs[2]  = mk(0, 2'b01, 0, 32'h42,  0,            3,  1, 32'hFFFF_8899, 0, 0);
    vecs[3]  = mk(0, 2'b01, 1, 32'h42,  0,            4,  1, 32'h0000_8899, 0, 0);
    vecs[4]  = mk(0, 2'b10, 0, 32'h40,  0,            5,  1, 32'h8899_AABB, 0, 0);
    vecs[5]  = mk(0, 2'b00, 0, 32'h42,  0,            6,  1, 32'hFFFF_FF99, 0, 0);
    vecs[6]  = mk(0, 2'b00, 1, 32'h43,  0,            7,  1, 32'h0000_0088, 0, 0);
    vecs[7]  = mk(1, 2'b10, 0, 32'h80,  32'h1234_5678, 0, 0, 32'h0,        0, 1);
    vecs[8]  = mk(0, 2'b10, 0, 32'h80,  0,            8,  1, 32'h1234_5678, 0, 0);
    vecs[9]  = mk(1, 2'b00, 0, 32'h83,  32'h0000_00EE, 0, 0, 32'h0,        0, 1);
    vecs[10] = mk(0, 2'b10, 0, 32'h80,  0,            9,  1, 32'hEE34_5678, 0, 0);
    vecs[11] = mk(1, 2'b01, 0, 32'h80,  32'h0000_BEEF, 0, 0, 32'h0,        0, 1);
    vecs[12] = mk(0, 2'b10, 0, 32'h80,  0,            10, 1, 32'hEE34_BEEF, 0, 0);
    vecs[13] = mk(0, 2'b10, 0, 32'h42,  0,            11, 0, 32'h0,        1, 0);
    vecs[14] = mk(1, 2'b01, 0, 32'h81,  32'h0000_1111, 0, 0, 32'h0,        1, 0);
    vecs[15] = mk(0, 2'b11, 0, 32'h44,  0,            12, 0, 32'h0,        1, 0);
    vecs[16] = mk(0, 2'b10, 0, 32'h480, 0,            13, 1, 32'hEE34_BEEF, 0, 0);
    vecs[17] = mk(0, 2'b01, 0, 32'h1,   0,            14, 0, 32'h0,        1, 0);

    // Reset state, with a live-looking request that must not reach the memory.
    drive(1, 2'b10, 0, 32'h84, 32'hFFFF_FFFF, 5'd3);
    @(negedge clk); #1;
    chk("rst_ready",      {31'b0, req_ready_o},  32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
    chk("rst_resp_rdata", resp_rdata_o,          32'h0);
    chk("rst_misalign",   {31'b0, misalign_o},   32'h0);
    chk("rst_exc_addr",   exc_addr_o,            32'h0);
    chk("rst_mem_we",     {30'b0, mem_req_o, mem_we_o}, 32'h0);
    chk("rst_mem_waddr",  mem_waddr_o,           32'h0);
    chk("rst_mem_wdata",  mem_wdata_o,           32'h0);
    chk("rst_mem_raddr",  mem_raddr_o,           32'h0);
    req_valid_i = 1'b0;
    preload(32'h40, 32'h8899_AABB);
    preload(32'h84, 32'h1122_3344);
    preload(32'hC0, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven single requests.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      w0 = wr_cnt;
      drive(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
      #1 chk($sformatf("v%0d_ready", i), {31'b0, req_ready_o}, 32'h1);
      @(negedge clk);
      req_valid_i = 1'b0;
      chk($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid_o}, {31'b0, vecs[i].exp_resp});
      if (vecs[i].exp_resp) begin
        chk($sformatf("v%0d_rdata", i), resp_rdata_o, vecs[i].exp_data);
        chk($sformatf("v%0d_rd", i), {27'b0, resp_rd_o}, {27'b0, vecs[i].rd});
      end
      chk($sformatf("v%0d_misalign", i), {31'b0, misalign_o}, {31'b0, vecs[i].exp_mis});
      if (vecs[i].exp_mis) chk($sformatf("v%0d_exc_addr", i), exc_addr_o, vecs[i].addr);
      @(negedge clk);
      chk($sformatf("v%0d_writes", i), wr_cnt - w0, vecs[i].exp_wr);
      chk($sformatf("v%0d_mis_clear", i), {31'b0, misalign_o}, 32'h0);
    end

    // Sub-word store: no write in accept cycle, one-cycle stall with merged write.
    @(negedge clk);
    drive(1, 2'b00, 0, 32'hC3, 32'h0000_00EE, 5'd0);
    #1 chk("sb_accept_we", {31'b0, mem_we_o}, 32'h0);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("sb_merge_ready", {31'b0, req_ready_o}, 32'h0);
    chk("sb_merge_we",    {30'b0, mem_req_o, mem_we_o}, 32'h3);
    chk("sb_merge_waddr", mem_waddr_o, 32'hC0);
    chk("sb_merge_wdata", mem_wdata_o, 32'hEE34_5678);
    @(negedge clk);
    chk("sb_after_ready", {31'b0, req_ready_o}, 32'h1);
    chk("sb_after_we",    {31'b0, mem_we_o}, 32'h0);
    chk("sb_after_wdata", mem_wdata_o, 32'h0);

    // Back-to-back with valid held high: LW, LW, SB, LW.
    @(negedge clk);
    drive(0, 2'b10, 0, 32'h40, 0, 5'd20);
    @(negedge clk);
    chk("b2b_c1_valid", {31'b0, resp_valid_o}, 32'h1);
    chk("b2b_c1_data",  resp_rdata_o, 32'h8899_AABB);
    chk("b2b_c1_rd",    {27'b0, resp_rd_o}, 32'd20);
    drive(0, 2'b10, 0, 32'h80, 0, 5'd21);
    @(negedge clk);
    chk("b2b_c2_valid", {31'b0, resp_valid_o}, 32'h1);
    chk("b2b_c2_data",  resp_rdata_o, 32'hEE34_BEEF);
    chk("b2b_c2_rd",    {27'b0, resp_rd_o}, 32'd21);
    drive(1, 2'b00, 0, 32'hC1, 32'h0000_0077, 5'd0);
    @(negedge clk);
    chk("b2b_c3_valid", {31'b0, resp_valid_o}, 32'h0);
    drive(0, 2'b10, 0, 32'hC0, 0, 5'd22);
    chk("b2b_c3_ready", {31'b0, req_ready_o}, 32'h0);
    @(negedge clk);
    chk("b2b_c4_valid", {31'b0, resp_valid_o}, 32'h0);
    chk("b2b_c4_ready", {31'b0, req_ready_o}, 32'h1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("b2b_c5_valid", {31'b0, resp_valid_o}, 32'h1);
    chk("b2b_c5_data",  resp_rdata_o, 32'hEE34_7778);
    chk("b2b_c5_rd",    {27'b0, resp_rd_o}, 32'd22);
    @(negedge clk);
    chk("b2b_c6_valid", {31'b0, resp_valid_o}, 32'h0);

    // Reset asserted mid-RMW: write abandoned, outputs cleared.
    @(negedge clk);
    drive(1, 2'b00, 0, 32'h84, 32'h0000_0055, 5'd0);
    @(negedge clk);
    req_valid_i = 1'b0;
    w0 = wr_cnt;
    rst = 1'b0;
    #1;
    chk("rmw_rst_we",     {30'b0, mem_req_o, mem_we_o}, 32'h0);
    chk("rmw_rst_waddr",  mem_waddr_o, 32'h0);
    chk("rmw_rst_wdata",  mem_wdata_o, 32'h0);
    chk("rmw_rst_raddr",  mem_raddr_o, 32'h0);
    chk("rmw_rst_resp",   {31'b0, resp_valid_o}, 32'h0);
    chk("rmw_rst_rdata",  resp_rdata_o, 32'h0);
    chk("rmw_rst_rd",     {27'b0, resp_rd_o}, 32'h0);
    chk("rmw_rst_exc",    exc_addr_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmw_rst_ready",  {31'b0, req_ready_o}, 32'h1);
    chk("rmw_rst_writes", wr_cnt - w0, 32'h0);
    chk("rmw_rst_word",   mem[8'h21], 32'h1122_3344);
    @(negedge clk);
    drive(0, 2'b10, 0, 32'h84, 0, 5'd7);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rmw_rst_load_valid", {31'b0, resp_valid_o}, 32'h1);
    chk("rmw_rst_load_data",  resp_rdata_o, 32'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
